// File: rtl/morse_sequencer.sv
// Morse keyer: sequences dot/dash marks and element/char/word gaps in whole unit ticks,
// with a one-entry skid buffer. Define MORSE_ABORT_EN to add the abort_i input.
module morse_sequencer #(
  parameter int unsigned DASH_UNITS     = 3,
  parameter int unsigned CHAR_GAP_UNITS = 3,
  parameter int unsigned WORD_GAP_UNITS = 7,
  parameter int unsigned MAX_LEN        = 6,
  parameter int unsigned CNT_W          = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               unit_i,
`ifdef MORSE_ABORT_EN
  input  logic               abort_i,
`endif
  input  logic               char_valid_i,
  output logic               char_ready_o,
  input  logic [2:0]         char_len_i,
  input  logic [MAX_LEN-1:0] char_bits_i,
  output logic               laser_o,
  output logic               busy_o,
  output logic               char_done_o
);

  typedef enum logic [2:0] {
    StIdle, StAlign, StMark, StGapElem, StGapChar, StGapWord
  } state_e;

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntDash = CNT_W'(DASH_UNITS);
  localparam logic [CNT_W-1:0] CntChar = CNT_W'(CHAR_GAP_UNITS);
  localparam logic [CNT_W-1:0] CntWord = CNT_W'(WORD_GAP_UNITS - CHAR_GAP_UNITS);
  localparam logic [2:0]       LenMax  = 3'(MAX_LEN);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [2:0]           cur_len_q, cur_len_d;
  logic [MAX_LEN-1:0]   cur_bits_q, cur_bits_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [2:0]           pend_len_q, pend_len_d;
  logic [MAX_LEN-1:0]   pend_bits_q, pend_bits_d;
  logic                 laser_q, laser_d;
  logic                 done_q, done_d;
  logic                 unit_q;

  logic                 tick;
  logic                 accept;
  logic                 consume;
  logic                 last_cnt;
  logic [2:0]           nxt_idx;
  state_e               start_state;
  logic [CNT_W-1:0]     start_cnt;
  logic                 start_laser;

  assign tick     = unit_i & ~unit_q;
  assign accept   = char_valid_i & ~pend_valid_q;
  assign last_cnt = (cnt_q == CntOne);
  assign nxt_idx  = idx_q + 3'd1;

  // First element (or word gap) of whatever sits in the buffer.
  always_comb begin
    start_state = StMark;
    start_cnt   = pend_bits_q[0] ? CntDash : CntOne;
    start_laser = 1'b1;
    if (pend_len_q == 3'd0) begin
      start_state = StGapWord;
      start_cnt   = CntWord;
      start_laser = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    cur_len_d    = cur_len_q;
    cur_bits_d   = cur_bits_q;
    pend_valid_d = pend_valid_q;
    pend_len_d   = pend_len_q;
    pend_bits_d  = pend_bits_q;
    laser_d      = laser_q;
    done_d       = 1'b0;
    consume      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pend_valid_q) state_d = StAlign;
      end
      StAlign: begin
        if (tick) consume = 1'b1;
      end
      StMark: begin
        if (tick) begin
          if (last_cnt) begin
            laser_d = 1'b0;
            if (nxt_idx < cur_len_q) begin
              state_d = StGapElem;
              cnt_d   = CntOne;
            end else begin
              state_d = StGapChar;
              cnt_d   = CntChar;
            end
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
      end
      StGapElem: begin
        if (tick) begin
          if (last_cnt) begin
            idx_d   = nxt_idx;
            state_d = StMark;
            laser_d = 1'b1;
            cnt_d   = cur_bits_q[nxt_idx] ? CntDash : CntOne;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
      end
      StGapChar, StGapWord: begin
        if (tick) begin
          if (last_cnt) begin
            done_d = 1'b1;
            if (pend_valid_q) consume = 1'b1;
            else              state_d = StIdle;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Chaining straight from a gap keeps exact spacing for back-to-back characters.
    if (consume) begin
      state_d      = start_state;
      cnt_d        = start_cnt;
      laser_d      = start_laser;
      idx_d        = 3'd0;
      cur_len_d    = pend_len_q;
      cur_bits_d   = pend_bits_q;
      pend_valid_d = 1'b0;
    end

    if (accept) begin
      pend_valid_d = 1'b1;
      pend_len_d   = (char_len_i > LenMax) ? LenMax : char_len_i;
      pend_bits_d  = char_bits_i;
    end

`ifdef MORSE_ABORT_EN
    if (abort_i) begin
      state_d      = StIdle;
      laser_d      = 1'b0;
      pend_valid_d = 1'b0;
      done_d       = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      cur_len_q    <= '0;
      cur_bits_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_len_q   <= '0;
      pend_bits_q  <= '0;
      laser_q      <= 1'b0;
      done_q       <= 1'b0;
      unit_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      cur_len_q    <= cur_len_d;
      cur_bits_q   <= cur_bits_d;
      pend_valid_q <= pend_valid_d;
      pend_len_q   <= pend_len_d;
      pend_bits_q  <= pend_bits_d;
      laser_q      <= laser_d;
      done_q       <= done_d;
      unit_q       <= unit_i;
    end
  end

  assign char_ready_o = ~pend_valid_q;
  assign laser_o      = laser_q;
  assign busy_o       = (state_q != StIdle) | pend_valid_q;
  assign char_done_o  = done_q;

endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer: unit period is 8 clocks, so 1 unit = 8 observed cycles.
module tb_morse_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       unit_i;
  logic       abort_i;
  logic       char_valid_i;
  logic       char_ready_o;
  logic [2:0] char_len_i;
  logic [5:0] char_bits_i;
  logic       laser_o;
  logic       busy_o;
  logic       char_done_o;

  int checks = 0;
  int errors = 0;

  morse_sequencer dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .unit_i       (unit_i),
`ifdef MORSE_ABORT_EN
    .abort_i      (abort_i),
`endif
    .char_valid_i (char_valid_i),
    .char_ready_o (char_ready_o),
    .char_len_i   (char_len_i),
    .char_bits_i  (char_bits_i),
    .laser_o      (laser_o),
    .busy_o       (busy_o),
    .char_done_o  (char_done_o)
  );

  always #5 clk_i = ~clk_i;

  // Unit clock: 4 cycles high, 4 low.
  initial begin
    int ph;
    ph = 0;
    unit_i = 1'b0;
    forever begin
      @(negedge clk_i);
      ph = (ph + 1) % 8;
      unit_i = (ph < 4);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_level(input logic lvl, input int budget, output int n);
    n = 0;
    while (laser_o !== lvl && n < budget) begin
      @(negedge clk_i);
      n++;
    end
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (char_done_o !== 1'b1 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
  endtask

  // Takes exactly one cycle once ready is seen.
  task automatic send_char(input logic [2:0] len, input logic [5:0] bits);
    int n;
    n = 0;
    while (char_ready_o !== 1'b1 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 500) check("send_ready_timeout", 32'(n), 32'd0);
    char_len_i   = len;
    char_bits_i  = bits;
    char_valid_i = 1'b1;
    @(negedge clk_i);
    char_valid_i = 1'b0;
  endtask

  initial begin
    int n;
    int dones;
    int bad;
    bit sent;

    rst_ni       = 1'b0;
    abort_i      = 1'b0;
    char_valid_i = 1'b0;
    char_len_i   = '0;
    char_bits_i  = '0;
    repeat (3) @(negedge clk_i);
    check("rst_laser", laser_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ready", char_ready_o, 1);
    check("rst_done", char_done_o, 0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // 'A': dot, dash
    send_char(3'd2, 6'b000010);
    wait_level(1'b1, 200, n);
    check("A_rise", laser_o, 1);
    check("A_busy", busy_o, 1);
    wait_level(1'b0, 200, n); check("A_dot_len", n, 8);
    wait_level(1'b1, 200, n); check("A_elem_gap", n, 8);
    wait_level(1'b0, 200, n); check("A_dash_len", n, 24);
    wait_done(200, n);        check("A_char_gap", n, 24);
    @(negedge clk_i);
    check("A_done_one_pulse", char_done_o, 0);
    check("A_busy_after", busy_o, 0);

    // 'E' then 'T' accepted during E's char gap
    send_char(3'd1, 6'b000000);
    wait_level(1'b1, 200, n);
    wait_level(1'b0, 200, n); check("E_mark_len", n, 8);
    send_char(3'd1, 6'b000001);
    check("ET_ready_low", char_ready_o, 0);
    wait_level(1'b1, 200, n); check("ET_char_gap", n + 1, 24);
    check("ET_ready_after_consume", char_ready_o, 1);
    wait_level(1'b0, 200, n); check("T_mark_len", n, 24);
    wait_done(200, n);        check("T_char_gap", n, 24);
    @(negedge clk_i);

    // 'E', word space, 'E'
    send_char(3'd1, 6'b000000);
    wait_level(1'b1, 200, n);
    send_char(3'd0, 6'b000000);
    wait_level(1'b0, 200, n); check("EwE_first_mark", n + 1, 8);
    n = 0; dones = 0; sent = 0;
    while (laser_o !== 1'b1 && n < 300) begin
      if (char_valid_i) char_valid_i = 1'b0;
      else if (!sent && char_ready_o) begin
        char_len_i   = 3'd1;
        char_bits_i  = 6'b000000;
        char_valid_i = 1'b1;
        sent = 1;
      end
      @(negedge clk_i);
      n++;
      if (char_done_o === 1'b1) dones++;
    end
    char_valid_i = 1'b0;
    check("EwE_silence", n, 56);
    check("EwE_done_count", dones, 2);
    wait_level(1'b0, 200, n); check("EwE_second_mark", n, 8);
    wait_done(200, n);        check("EwE_char_gap", n, 24);
    @(negedge clk_i);

    // Length 7 clamps to 6 dashes
    send_char(3'd7, 6'b111111);
    for (int i = 0; i < 6; i++) begin
      wait_level(1'b1, 200, n);
      if (i > 0) check($sformatf("clamp_gap%0d", i), n, 8);
      wait_level(1'b0, 200, n);
      check($sformatf("clamp_mark%0d", i), n, 24);
    end
    wait_done(200, n); check("clamp_char_gap", n, 24);
    @(negedge clk_i);
    check("clamp_busy_after", busy_o, 0);

    // Async reset mid-dash
    send_char(3'd1, 6'b000001);
    wait_level(1'b1, 200, n);
    repeat (10) @(negedge clk_i);
    check("rstmid_laser_before", laser_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("rstmid_laser", laser_o, 0);
    check("rstmid_busy", busy_o, 0);
    check("rstmid_ready", char_ready_o, 1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (laser_o !== 1'b0 || char_done_o !== 1'b0 || busy_o !== 1'b0) bad++;
    end
    check("rstmid_idle_quiet", bad, 0);

`ifdef MORSE_ABORT_EN
    // Abort during A's dash with E pending
    send_char(3'd2, 6'b000010);
    wait_level(1'b1, 200, n);
    wait_level(1'b0, 200, n);
    wait_level(1'b1, 200, n);
    send_char(3'd1, 6'b000000);
    check("abort_pending", char_ready_o, 0);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("abort_laser", laser_o, 0);
    check("abort_ready", char_ready_o, 1);
    check("abort_busy", busy_o, 0);
    bad = 0;
    repeat (60) begin
      @(negedge clk_i);
      if (laser_o !== 1'b0 || char_done_o !== 1'b0) bad++;
    end
    check("abort_quiet", bad, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
